// File: rtl/reg_file_banked_pkg.sv
// Shared processor datapath constants used by the register file.
// WORD_W     : datapath word width in bits
// REG_COUNT  : number of architectural registers
// REG_ADDR_W : register address width
// REG_ZERO   : address of the hard-wired zero register
package reg_file_banked_pkg;
  localparam int WORD_W     = 16;
  localparam int REG_COUNT  = 16;
  localparam int REG_ADDR_W = 4;
  localparam int REG_ZERO   = 0;
endpackage

// File: rtl/reg_file_banked_if.sv
// Register file bus: two read ports, one write port, and the interrupt
// controller's save/restore controls plus shadow status.
// master : decode/writeback/interrupt side (drives addresses, write data, save/restore)
// slave  : the register file (drives read data, shadow_valid, busy_err)
interface reg_file_banked_if
  import reg_file_banked_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int AW    = REG_ADDR_W
);
  logic [AW-1:0]    rd_addr_a;
  logic [WIDTH-1:0] rd_data_a;
  logic [AW-1:0]    rd_addr_b;
  logic [WIDTH-1:0] rd_data_b;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic             save;
  logic             restore;
  logic             shadow_valid;
  logic             busy_err;

  modport master (
    output rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data, save, restore,
    input  rd_data_a, rd_data_b, shadow_valid, busy_err
  );

  modport slave (
    input  rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data, save, restore,
    output rd_data_a, rd_data_b, shadow_valid, busy_err
  );
endinterface

// File: rtl/reg_file_read_port.sv
// One combinational read port of the register file.
// bank    : flattened main bank contents
// rd_addr : read address; rd_data : read result (no latency)
// wr_en/wr_addr/wr_data : current write, used for write-first bypass
// Register 0 reads as zero when ZERO_REG is set, even if it is being written.
module reg_file_read_port
  import reg_file_banked_pkg::*;
#(
  parameter int WIDTH    = WORD_W,
  parameter int DEPTH    = REG_COUNT,
  parameter int AW       = REG_ADDR_W,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic [DEPTH-1:0][WIDTH-1:0] bank,
  input  logic [AW-1:0]               rd_addr,
  input  logic                        wr_en,
  input  logic [AW-1:0]               wr_addr,
  input  logic [WIDTH-1:0]            wr_data,
  output logic [WIDTH-1:0]            rd_data
);
  localparam logic [AW-1:0] ZERO_ADDR = AW'(REG_ZERO);

  logic is_zero;
  logic bypass_hit;

  always_comb begin
    is_zero    = (ZERO_REG != 0) && (rd_addr == ZERO_ADDR);
    bypass_hit = (BYPASS != 0) && wr_en && (wr_addr == rd_addr);
    // The zero check comes first so a write to r0 can never leak through bypass.
    if (is_zero) begin
      rd_data = '0;
    end else if (bypass_hit) begin
      rd_data = wr_data;
    end else begin
      rd_data = bank[rd_addr];
    end
  end
endmodule

// File: rtl/reg_file_banked.sv
// Banked register file for the 16-bit datapath.
// clk   : single clock, all state updates on the rising edge
// rst_n : synchronous active-low reset, clears both banks and status
// bus   : slave side of reg_file_banked_if (read ports A/B, write port,
//         save/restore, shadow_valid, busy_err)
// The shadow bank is a one-deep snapshot of the whole file used for
// interrupt context save/return; it is never readable directly.
module reg_file_banked
  import reg_file_banked_pkg::*;
#(
  parameter int WIDTH    = WORD_W,
  parameter int DEPTH    = REG_COUNT,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  reg_file_banked_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] ZERO_ADDR = AW'(REG_ZERO);

  logic [DEPTH-1:0][WIDTH-1:0] main_reg;
  logic [DEPTH-1:0][WIDTH-1:0] shadow_reg;
  logic                        shadow_valid_reg;
  logic                        busy_err_reg;

  logic                        wr_ok;
  logic                        do_save;
  logic                        do_restore;

  logic [1:0][AW-1:0]          rd_addr;
  logic [1:0][WIDTH-1:0]       rd_data;

  // Writes to the zero register are dropped before they reach the bank.
  assign wr_ok      = bus.wr_en && !((ZERO_REG != 0) && (bus.wr_addr == ZERO_ADDR));
  // Simultaneous save and restore cancels both.
  assign do_save    = bus.save && !bus.restore;
  assign do_restore = bus.restore && !bus.save;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_reg         <= '0;
      shadow_reg       <= '0;
      shadow_valid_reg <= 1'b0;
      busy_err_reg     <= 1'b0;
    end else begin
      busy_err_reg <= bus.save && bus.restore;
      if (do_save) begin
        // Captures pre-edge contents, so a concurrent write is not snapshotted.
        shadow_reg       <= main_reg;
        shadow_valid_reg <= 1'b1;
      end
      if (do_restore) begin
        main_reg         <= shadow_reg;
        shadow_valid_reg <= 1'b0;
      end
      // Placed after the restore copy so a concurrent write wins for its address.
      if (wr_ok) begin
        main_reg[bus.wr_addr] <= bus.wr_data;
      end
    end
  end

  assign rd_addr[0]       = bus.rd_addr_a;
  assign rd_addr[1]       = bus.rd_addr_b;
  assign bus.rd_data_a    = rd_data[0];
  assign bus.rd_data_b    = rd_data[1];
  assign bus.shadow_valid = shadow_valid_reg;
  assign bus.busy_err     = busy_err_reg;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_rd_port
      reg_file_read_port #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .AW       (AW),
        .ZERO_REG (ZERO_REG),
        .BYPASS   (BYPASS)
      ) u_rd_port (
        .bank    (main_reg),
        .rd_addr (rd_addr[gi]),
        .wr_en   (bus.wr_en),
        .wr_addr (bus.wr_addr),
        .wr_data (bus.wr_data),
        .rd_data (rd_data[gi])
      );
    end
  endgenerate
endmodule

// File: tb/tb_reg_file_banked.sv
// Bench for reg_file_banked: two instances share one stimulus stream, one
// with write-first bypass and one without. Stimulus pushes expected values
// into a scoreboard queue; a monitor on the falling edge pops and compares.
module tb_reg_file_banked;
  import reg_file_banked_pkg::*;

  localparam int SEL_A    = 0;
  localparam int SEL_B    = 1;
  localparam int SEL_SV   = 2;
  localparam int SEL_BUSY = 3;
  localparam int SEL_NB_A = 4;
  localparam int SEL_NB_B = 5;

  typedef struct {
    string       name;
    int          sel;
    logic [15:0] exp;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_bad;
  exp_t sb_q[$];

  reg_file_banked_if #(.WIDTH(16), .AW(4)) bus ();
  reg_file_banked_if #(.WIDTH(16), .AW(4)) nb_bus ();

  reg_file_banked #(.WIDTH(16), .DEPTH(16), .ZERO_REG(1), .BYPASS(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  reg_file_banked #(.WIDTH(16), .DEPTH(16), .ZERO_REG(1), .BYPASS(0)) dut_nb (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (nb_bus.slave)
  );

  assign nb_bus.rd_addr_a = bus.rd_addr_a;
  assign nb_bus.rd_addr_b = bus.rd_addr_b;
  assign nb_bus.wr_en     = bus.wr_en;
  assign nb_bus.wr_addr   = bus.wr_addr;
  assign nb_bus.wr_data   = bus.wr_data;
  assign nb_bus.save      = bus.save;
  assign nb_bus.restore   = bus.restore;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] actual(input int sel);
    case (sel)
      SEL_A:    return bus.rd_data_a;
      SEL_B:    return bus.rd_data_b;
      SEL_SV:   return {15'b0, bus.shadow_valid};
      SEL_BUSY: return {15'b0, bus.busy_err};
      SEL_NB_A: return nb_bus.rd_data_a;
      default:  return nb_bus.rd_data_b;
    endcase
  endfunction

  task automatic push(input string nm, input int sel, input logic [15:0] v);
    exp_t e;
    e.name = nm;
    e.sel  = sel;
    e.exp  = v;
    sb_q.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Monitor: outputs are combinational or registered, so they are stable
  // mid-cycle; everything queued for this cycle is checked here.
  always @(negedge clk) begin
    while (sb_q.size() > 0) begin
      exp_t e;
      logic [15:0] got;
      e   = sb_q.pop_front();
      got = actual(e.sel);
      n_vec++;
      if (got !== e.exp) begin
        n_bad++;
        $display("FAIL %s: got %h expected %h", e.name, got, e.exp);
      end else begin
        $display("ok   %s: %h", e.name, got);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst_n          = 1'b0;
    bus.rd_addr_a  = '0;
    bus.rd_addr_b  = '0;
    bus.wr_en      = 1'b0;
    bus.wr_addr    = '0;
    bus.wr_data    = '0;
    bus.save       = 1'b0;
    bus.restore    = 1'b0;
    cyc();
    rst_n = 1'b1;

    // Reset state: every register reads zero, status clear.
    push("reset_shadow_valid", SEL_SV, 16'h0000);
    push("reset_busy_err", SEL_BUSY, 16'h0000);
    for (int i = 0; i < 16; i++) begin
      bus.rd_addr_a = 4'(i);
      push($sformatf("reset_read_r%0d", i), SEL_A, 16'h0000);
      cyc();
    end

    // Write r3 with same-cycle read: bypass vs no bypass.
    bus.wr_en = 1'b1; bus.wr_addr = 4'd3; bus.wr_data = 16'hBEEF; bus.rd_addr_a = 4'd3;
    push("bypass_same_cycle", SEL_A, 16'hBEEF);
    push("nobypass_same_cycle", SEL_NB_A, 16'h0000);
    cyc();
    bus.wr_en = 1'b0;
    push("bypass_after_edge", SEL_A, 16'hBEEF);
    push("nobypass_after_edge", SEL_NB_A, 16'hBEEF);
    cyc();

    // Zero register ignores writes, even via bypass.
    bus.wr_en = 1'b1; bus.wr_addr = 4'd0; bus.wr_data = 16'h1234; bus.rd_addr_b = 4'd0;
    push("zero_reg_bypass", SEL_B, 16'h0000);
    push("zero_reg_nobypass", SEL_NB_B, 16'h0000);
    cyc();
    bus.wr_en = 1'b0;
    push("zero_reg_after", SEL_B, 16'h0000);
    cyc();

    // Save with concurrent write to r5.
    bus.wr_en = 1'b1; bus.wr_addr = 4'd5; bus.wr_data = 16'h0055;
    cyc();
    bus.save = 1'b1; bus.wr_data = 16'h0AAA; bus.rd_addr_a = 4'd5;
    push("save_wr_bypass", SEL_A, 16'h0AAA);
    push("save_wr_nobypass", SEL_NB_A, 16'h0055);
    cyc();
    bus.save = 1'b0; bus.wr_en = 1'b0;
    push("save_wr_landed", SEL_A, 16'h0AAA);
    push("save_shadow_valid", SEL_SV, 16'h0001);
    cyc();
    bus.restore = 1'b1;
    push("restore_not_bypassed", SEL_A, 16'h0AAA);
    cyc();
    bus.restore = 1'b0;
    push("restore_r5", SEL_A, 16'h0055);
    push("restore_shadow_valid", SEL_SV, 16'h0000);
    cyc();

    // Restore with concurrent write to r7.
    bus.wr_en = 1'b1; bus.wr_addr = 4'd2; bus.wr_data = 16'h0022;
    cyc();
    bus.wr_addr = 4'd7; bus.wr_data = 16'h0077;
    cyc();
    bus.wr_en = 1'b0; bus.save = 1'b1;
    cyc();
    bus.save = 1'b0; bus.wr_en = 1'b1; bus.wr_addr = 4'd2; bus.wr_data = 16'hFFFF;
    cyc();
    bus.restore = 1'b1; bus.wr_addr = 4'd7; bus.wr_data = 16'h7777; bus.rd_addr_a = 4'd7;
    push("restore_wr_bypass", SEL_A, 16'h7777);
    cyc();
    bus.restore = 1'b0; bus.wr_en = 1'b0; bus.rd_addr_a = 4'd2; bus.rd_addr_b = 4'd7;
    push("restore_wr_r2", SEL_A, 16'h0022);
    push("restore_wr_r7", SEL_B, 16'h7777);
    push("restore_wr_nb_r7", SEL_NB_B, 16'h7777);
    cyc();

    // Save/restore conflict: neither happens, write still lands, busy_err pulses.
    bus.save = 1'b1;
    cyc();
    bus.restore = 1'b1; bus.wr_en = 1'b1; bus.wr_addr = 4'd1; bus.wr_data = 16'h0011;
    push("conflict_busy_before", SEL_BUSY, 16'h0000);
    cyc();
    bus.save = 1'b0; bus.restore = 1'b0; bus.wr_addr = 4'd2; bus.wr_data = 16'h2222;
    bus.rd_addr_a = 4'd1;
    push("conflict_write_r1", SEL_A, 16'h0011);
    push("conflict_busy_pulse", SEL_BUSY, 16'h0001);
    push("conflict_shadow_valid", SEL_SV, 16'h0001);
    cyc();
    bus.wr_en = 1'b0; bus.restore = 1'b1;
    push("conflict_busy_cleared", SEL_BUSY, 16'h0000);
    cyc();
    bus.restore = 1'b0; bus.rd_addr_a = 4'd1; bus.rd_addr_b = 4'd2;
    push("conflict_shadow_r1", SEL_A, 16'h0000);
    push("conflict_shadow_r2", SEL_B, 16'h0022);
    cyc();

    // Reset with a save pending: everything cleared, save discarded.
    bus.save = 1'b1;
    cyc();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1; bus.save = 1'b0;
    push("rst_shadow_valid", SEL_SV, 16'h0000);
    push("rst_busy_err", SEL_BUSY, 16'h0000);
    for (int i = 0; i < 16; i++) begin
      bus.rd_addr_a = 4'(i);
      push($sformatf("rst_read_r%0d", i), SEL_A, 16'h0000);
      cyc();
    end
    bus.restore = 1'b1;
    cyc();
    bus.restore = 1'b0; bus.rd_addr_a = 4'd3; bus.rd_addr_b = 4'd7;
    push("rst_restore_r3", SEL_A, 16'h0000);
    push("rst_restore_r7", SEL_B, 16'h0000);
    push("rst_restore_shadow_valid", SEL_SV, 16'h0000);
    cyc();

    @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
